// File: rtl/iot_pkg.sv
// iot_pkg: shared types and constants for the IoT device event arbiter
package iot_pkg;
    localparam int N_DEV_DEFAULT = 8;
    typedef logic [$clog2(N_DEV_DEFAULT)-1:0] dev_id_t;
    localparam logic EV_ON  = 1'b1;
    localparam logic EV_OFF = 1'b0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr and wrapping
module rr_arbiter
    import iot_pkg::*;
#(
    parameter int N = N_DEV_DEFAULT,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);
    function automatic logic [W-1:0] wrap(input logic [W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return W'(s >= N ? s - N : s);
    endfunction

    // Scanning from the farthest offset down lets the nearest request overwrite earlier hits.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(ptr, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx = wrap(ptr, k);
            end
        end
    end
endmodule

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: detects per-device on/off edges and issues one round-robin event per cycle
module iot_event_arbiter
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT,
    localparam int ID_W = $clog2(N_DEV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic             busy
);
    logic [N_DEV-1:0] status_q, pending, pend_dir, dev_edge, gnt_oh, pending_next, load_dir;
    logic [ID_W-1:0] rr_ptr, gnt_idx;
    logic gnt_valid;

    rr_arbiter #(.N(N_DEV)) u_arb (
        .req(pending),
        .ptr(rr_ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );

    // A fresh edge on a still-queued device cancels it; otherwise it (re)arms the slot.
    always_comb begin
        dev_edge = dev_status ^ status_q;
        gnt_oh = gnt_valid ? (N_DEV'(1) << gnt_idx) : '0;
        pending_next = (pending & ~gnt_oh) ^ dev_edge;
        load_dir = dev_edge & pending_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            pending <= '0;
            pend_dir <= '0;
            rr_ptr <= '0;
            change <= 1'b0;
            on_off <= EV_OFF;
            dev_id <= '0;
            busy <= 1'b0;
        end else begin
            status_q <= dev_status;
            pending <= pending_next;
            pend_dir <= (load_dir & dev_status) | (~load_dir & pend_dir);
            change <= gnt_valid;
            on_off <= gnt_valid ? pend_dir[gnt_idx] : EV_OFF;
            dev_id <= gnt_valid ? gnt_idx : '0;
            if (gnt_valid)
                rr_ptr <= (gnt_idx == ID_W'(N_DEV - 1)) ? '0 : gnt_idx + 1'b1;
            busy <= |pending_next;
        end
    end
endmodule

// File: tb/tb_iot_event_arbiter.sv
// tb_iot_event_arbiter: randomized and directed checks against a per-device event model
module tb_iot_event_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] dev_status = '0;
    logic change, on_off, busy;
    logic [1:0] dev_id;
    logic [4:0] obs;

    int checks = 0;
    int errors = 0;
    int m_pend[N], m_dir[N], m_stat[N];
    int m_ptr, m_change, m_onoff, m_id, m_busy;
    int net = 0;

    iot_event_arbiter #(.N_DEV(N)) dut (
        .clk(clk),
        .rst(rst),
        .dev_status(dev_status),
        .change(change),
        .on_off(on_off),
        .dev_id(dev_id),
        .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = {change, on_off, dev_id, busy};

    // Model: each device owns one queue slot; the oldest-in-rotation slot is served per cycle.
    task automatic model_step(input logic r, input logic [N-1:0] st);
        int g, gdir, granted, e;
        if (r) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_dir[i] = 0;
                m_stat[i] = 0;
            end
            m_ptr = 0; m_change = 0; m_onoff = 0; m_id = 0; m_busy = 0;
            return;
        end
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && m_pend[(m_ptr + k) % N] == 1) g = (m_ptr + k) % N;
        gdir = 0;
        if (g >= 0) gdir = m_dir[g];
        for (int i = 0; i < N; i++) begin
            granted = (i == g);
            e = (int'(st[i]) != m_stat[i]);
            if (e) begin
                if (m_pend[i] == 1 && !granted) m_pend[i] = 0;
                else begin
                    m_pend[i] = 1;
                    m_dir[i] = int'(st[i]);
                end
            end else if (granted) m_pend[i] = 0;
            m_stat[i] = int'(st[i]);
        end
        m_change = (g >= 0);
        m_onoff = gdir;
        m_id = (g >= 0) ? g : 0;
        if (g >= 0) m_ptr = (g + 1) % N;
        m_busy = 0;
        for (int i = 0; i < N; i++) m_busy |= m_pend[i];
    endtask

    function automatic logic [4:0] exp_v();
        return {1'(m_change), 1'(m_onoff), 2'(m_id), 1'(m_busy)};
    endfunction

    task automatic step(input logic r, input logic [N-1:0] st);
        rst = r;
        dev_status = st;
        @(posedge clk);
        model_step(r, st);
        #1;
        if (r) net = 0;
        else if (change) net += on_off ? 1 : -1;
    endtask

    task automatic test_reset();
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 5'b0);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 4'b0000);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs, 5'b0);
            end
        end
    endtask

    task automatic test_single_on();
        step(1'b0, 4'b0100);
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL single_pending got=%b exp=%b", obs, 5'b00001);
        end
        step(1'b0, 4'b0100);
        checks++;
        if (obs !== 5'b11100) begin
            errors++;
            $display("FAIL single_pulse got=%b exp=%b", obs, 5'b11100);
        end
        step(1'b0, 4'b0100);
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL single_after got=%b exp=%b", obs, 5'b0);
        end
    endtask

    task automatic test_rr_order();
        int exp_ids[4] = '{2, 3, 0, 1};
        logic [4:0] want;
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        checks++;
        if (obs !== 5'b10010) begin
            errors++;
            $display("FAIL rr_setup_off got=%b exp=%b", obs, 5'b10010);
        end
        step(1'b0, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b1111);
            want = {1'b1, 1'b1, 2'(exp_ids[k]), 1'(k < 3)};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL rr_order k=%0d got=%b exp=%b", k, obs, want);
            end
        end
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0000);
        checks++;
        if ({change, on_off, dev_id} !== 4'b1010) begin
            errors++;
            $display("FAIL rr_next_ptr got=%b exp=%b", {change, on_off, dev_id}, 4'b1010);
        end
        for (int c = 0; c < 4; c++) step(1'b0, 4'b0000);
    endtask

    task automatic test_cancel();
        int pulses = 0;
        int dev1 = 0;
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0011);
        for (int c = 0; c < 7; c++) begin
            step(1'b0, 4'b0001);
            if (change) pulses++;
            if (change && dev_id == 2'd1) dev1++;
            checks++;
            if (obs !== exp_v()) begin
                errors++;
                $display("FAIL cancel_model cyc=%0d got=%b exp=%b", c, obs, exp_v());
            end
        end
        checks++;
        if (pulses != 1 || dev1 != 0) begin
            errors++;
            $display("FAIL cancel_count got=%0d/%0d exp=1/0", pulses, dev1);
        end
    endtask

    task automatic test_toggle_grant();
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b0000);
        checks++;
        if (obs !== 5'b11111) begin
            errors++;
            $display("FAIL toggle_on_pulse got=%b exp=%b", obs, 5'b11111);
        end
        step(1'b0, 4'b0000);
        checks++;
        if (obs !== 5'b10110) begin
            errors++;
            $display("FAIL toggle_off_pulse got=%b exp=%b", obs, 5'b10110);
        end
    endtask

    task automatic test_reset_mid_drain();
        int ons = 0;
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1111);
        step(1'b0, 4'b1111);
        checks++;
        if (obs !== 5'b11001) begin
            errors++;
            $display("FAIL drain_first got=%b exp=%b", obs, 5'b11001);
        end
        step(1'b1, 4'b1111);
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL drain_reset got=%b exp=%b", obs, 5'b0);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 4'b1111);
            if (change && on_off) ons++;
            checks++;
            if (obs !== exp_v()) begin
                errors++;
                $display("FAIL drain_model cyc=%0d got=%b exp=%b", c, obs, exp_v());
            end
        end
        checks++;
        if (ons != 4) begin
            errors++;
            $display("FAIL drain_on_pulses got=%0d exp=4", ons);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] st;
        step(1'b1, 4'b0000);
        for (int c = 0; c < 600; c++) begin
            st = dev_status;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) st[i] = ~st[i];
            step(1'($urandom_range(0, 99) == 0), st);
            checks++;
            if (obs !== exp_v()) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", c, obs, exp_v());
            end
        end
        for (int c = 0; c < 2 * N + 4; c++) begin
            step(1'b0, dev_status);
            checks++;
            if (obs !== exp_v()) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got=%b exp=%b", c, obs, exp_v());
            end
        end
        checks++;
        if (busy !== 1'b0 || net != $countones(dev_status)) begin
            errors++;
            $display("FAIL invariant busy=%b net=%0d exp busy=0 net=%0d", busy, net, $countones(dev_status));
        end
    endtask

    initial begin
        test_reset();
        test_single_on();
        test_rr_order();
        test_cancel();
        test_toggle_grant();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
